freelist: RTL and testbench

Physical-register free list for the rename stage. It hands out up to two free physical registers per cycle to rename. It consumes the ROB commit port, returning each committing instruction's `old_prd` to the pool. It keeps a committed (architectural) head pointer, so a redirect restores the speculative allocation state in one cycle without walking the ROB.

---
 rtl/freelist.sv | 98 +++++++++
 tb/tb_freelist.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freelist.sv
// Physical-register free list for rename: hands out up to two pregs per cycle,
// reclaims old mappings from ROB commits and restores speculative state on redirect.
module freelist #(
   parameter int PREG_NUM = 64,
   parameter int PREG_W   = 6,
   parameter int ARCH_NUM = 32,
   parameter int DEPTH    = PREG_NUM - ARCH_NUM,
   parameter int PTR_W    = 5
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                alloc0_req,
   input  logic                alloc1_req,
   output logic                alloc_ready,
   output logic [PREG_W-1:0]   alloc0_prd,
   output logic [PREG_W-1:0]   alloc1_prd,
   output logic [PTR_W:0]      free_count,
   input  logic                commits0_valid,
   input  logic [4:0]          commits0_lrd,
   input  logic [PREG_W-1:0]   commits0_old_prd,
   input  logic                commits1_valid,
   input  logic [4:0]          commits1_lrd,
   input  logic [PREG_W-1:0]   commits1_old_prd,
   input  logic                redirect_valid
);

   // Pointers carry the wrap flag in their MSB, so plain subtraction gives occupancy.
   logic [PREG_W-1:0] entries_q [DEPTH];
   logic [PTR_W:0]    specHead_q, specHead_d;
   logic [PTR_W:0]    archHead_q, archHead_d;
   logic [PTR_W:0]    tail_q, tail_d;

   logic [PTR_W-1:0]  allocIdx1;
   logic [PTR_W-1:0]  writeIdx0;
   logic [PTR_W-1:0]  writeIdx1;
   logic              free0;
   logic              free1;
   logic [1:0]        freeNum;
   logic [1:0]        allocNum;

   assign free_count  = tail_q - specHead_q;
   assign alloc_ready = (free_count >= (PTR_W+1)'(2));

   assign allocIdx1  = specHead_q[PTR_W-1:0] + PTR_W'(alloc0_req);
   assign alloc0_prd = entries_q[specHead_q[PTR_W-1:0]];
   assign alloc1_prd = entries_q[allocIdx1];

   assign free0     = commits0_valid && (commits0_lrd != 5'd0);
   assign free1     = commits1_valid && (commits1_lrd != 5'd0);
   assign freeNum   = {1'b0, free0} + {1'b0, free1};
   assign writeIdx0 = tail_q[PTR_W-1:0];
   assign writeIdx1 = tail_q[PTR_W-1:0] + PTR_W'(free0);

   // Each commit with a destination retires exactly one allocation, so the
   // committed head moves in lockstep with the tail.
   always_comb begin
      allocNum   = 2'd0;
      tail_d     = tail_q + (PTR_W+1)'(freeNum);
      archHead_d = archHead_q + (PTR_W+1)'(freeNum);
      if (alloc_ready && !redirect_valid) begin
         allocNum = {1'b0, alloc0_req} + {1'b0, alloc1_req};
      end
      if (redirect_valid) begin
         specHead_d = archHead_d;
      end else begin
         specHead_d = specHead_q + (PTR_W+1)'(allocNum);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         specHead_q <= '0;
         archHead_q <= '0;
         tail_q     <= {1'b1, {PTR_W{1'b0}}};
      end else begin
         specHead_q <= specHead_d;
         archHead_q <= archHead_d;
         tail_q     <= tail_d;
      end
   end

   // Freed pregs land at the tail; slot 1 follows slot 0 only when slot 0 frees.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= PREG_W'(ARCH_NUM + i);
         end
      end else begin
         if (free0) begin
            entries_q[writeIdx0] <= commits0_old_prd;
         end
         if (free1) begin
            entries_q[writeIdx1] <= commits1_old_prd;
         end
      end
   end

endmodule

// File: tb/tb_freelist.sv
// Directed bench for freelist: expected outputs are queued per step and
// compared against the DUT just after each drive, away from the clock edge.
module tb_freelist;

   logic       clock;
   logic       reset_n;
   logic       alloc0_req, alloc1_req;
   logic       alloc_ready;
   logic [5:0] alloc0_prd, alloc1_prd;
   logic [5:0] free_count;
   logic       commits0_valid, commits1_valid;
   logic [4:0] commits0_lrd, commits1_lrd;
   logic [5:0] commits0_old_prd, commits1_old_prd;
   logic       redirect_valid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string tag;
      int    sel;
      int    val;
   } expItem_t;

   expItem_t sb[$];

   freelist dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .alloc0_req       (alloc0_req),
      .alloc1_req       (alloc1_req),
      .alloc_ready      (alloc_ready),
      .alloc0_prd       (alloc0_prd),
      .alloc1_prd       (alloc1_prd),
      .free_count       (free_count),
      .commits0_valid   (commits0_valid),
      .commits0_lrd     (commits0_lrd),
      .commits0_old_prd (commits0_old_prd),
      .commits1_valid   (commits1_valid),
      .commits1_lrd     (commits1_lrd),
      .commits1_old_prd (commits1_old_prd),
      .redirect_valid   (redirect_valid)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Occupancy can never exceed capacity while out of reset.
   always @(negedge clock) begin
      if (reset_n === 1'b1) begin
         checks++;
         assert (free_count <= 6'd32) else begin
            errors++;
            $error("[TB] FAIL free_count_bound observed=%0d expected<=32", free_count);
         end
      end
   end

   task automatic applyStimulus(input logic a0, input logic a1,
                                input logic c0v, input logic [4:0] c0lrd, input logic [5:0] c0old,
                                input logic c1v, input logic [4:0] c1lrd, input logic [5:0] c1old,
                                input logic redir);
      alloc0_req       = a0;
      alloc1_req       = a1;
      commits0_valid   = c0v;
      commits0_lrd     = c0lrd;
      commits0_old_prd = c0old;
      commits1_valid   = c1v;
      commits1_lrd     = c1lrd;
      commits1_old_prd = c1old;
      redirect_valid   = redir;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 5'd0, 6'd0, 0, 5'd0, 6'd0, 0);
   endtask

   // sel: 0 alloc0_prd, 1 alloc1_prd, 2 free_count, 3 alloc_ready
   task automatic expectOut(input string tag, input int sel, input int val);
      expItem_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      expItem_t    e;
      logic [31:0] obs;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.sel)
            0:       obs = 32'(alloc0_prd);
            1:       obs = 32'(alloc1_prd);
            2:       obs = 32'(free_count);
            default: obs = 32'(alloc_ready);
         endcase
         checks++;
         assert (obs === 32'(e.val)) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic pulseReset();
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
   endtask

   task automatic expectResetOutputs(input string tag);
      expectOut({tag, "_alloc0"}, 0, 32);
      expectOut({tag, "_alloc1"}, 1, 33);
      expectOut({tag, "_count"},  2, 32);
      expectOut({tag, "_ready"},  3, 1);
   endtask

   initial begin
      reset_n = 1'b0;
      idle();
      @(negedge clock);
      reset_n = 1'b1;

      // Reset state; alloc1_prd follows the head only when slot 0 does not request.
      expectOut("rst_alloc0", 0, 32);
      expectOut("rst_count",  2, 32);
      expectOut("rst_ready",  3, 1);
      checkOutput();
      alloc0_req = 1'b1;
      expectOut("rst_alloc1", 1, 33);
      checkOutput();
      alloc0_req = 1'b0;
      cycle();

      // Single allocation on slot 1 takes the head entry.
      applyStimulus(0, 1, 0, 5'd0, 6'd0, 0, 5'd0, 6'd0, 0);
      expectOut("single_alloc1", 1, 32);
      checkOutput();
      cycle();
      idle();
      expectOut("single_next_alloc0", 0, 33);
      expectOut("single_next_count",  2, 31);
      checkOutput();

      // Drain from a fresh reset with dual allocations.
      pulseReset();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1, 1, 0, 5'd0, 6'd0, 0, 5'd0, 6'd0, 0);
         expectOut("drain_alloc0", 0, 32 + 2*i);
         expectOut("drain_alloc1", 1, 33 + 2*i);
         expectOut("drain_count",  2, 32 - 2*i);
         checkOutput();
         cycle();
      end
      for (int i = 0; i < 2; i++) begin
         expectOut("empty_count",  2, 0);
         expectOut("empty_ready",  3, 0);
         expectOut("empty_alloc0", 0, 32);
         checkOutput();
         cycle();
      end

      // Refill: frees do not bypass into the same cycle.
      applyStimulus(0, 0, 1, 5'd3, 6'd5, 1, 5'd4, 6'd7, 0);
      expectOut("refill_same_count", 2, 0);
      expectOut("refill_same_ready", 3, 0);
      checkOutput();
      cycle();
      idle();
      expectOut("refill_count",  2, 2);
      expectOut("refill_ready",  3, 1);
      expectOut("refill_alloc0", 0, 5);
      checkOutput();
      alloc0_req = 1'b1;
      expectOut("refill_alloc1", 1, 7);
      checkOutput();
      cycle();

      // One allocation consumed preg 5; a commit with lrd=0 frees nothing.
      applyStimulus(0, 0, 1, 5'd0, 6'd9, 0, 5'd0, 6'd0, 0);
      expectOut("after_alloc_count",  2, 1);
      expectOut("after_alloc_alloc0", 0, 7);
      expectOut("after_alloc_ready",  3, 0);
      checkOutput();
      cycle();
      applyStimulus(0, 0, 1, 5'd0, 6'd0, 1, 5'd6, 6'd12, 0);
      expectOut("lrd0_count", 2, 1);
      checkOutput();
      cycle();

      // Only slot 1 freed, so preg 12 lands directly at the tail.
      idle();
      expectOut("slot1_free_count", 2, 2);
      checkOutput();
      alloc0_req = 1'b1;
      expectOut("slot1_free_alloc1", 1, 12);
      checkOutput();
      alloc0_req = 1'b0;
      cycle();

      // Redirect restores the head to the committed pointer including this cycle's commit.
      pulseReset();
      applyStimulus(1, 1, 0, 5'd0, 6'd0, 0, 5'd0, 6'd0, 0);
      expectOut("redir_a_alloc0", 0, 32);
      expectOut("redir_a_alloc1", 1, 33);
      checkOutput();
      cycle();
      expectOut("redir_b_alloc0", 0, 34);
      expectOut("redir_b_alloc1", 1, 35);
      checkOutput();
      cycle();
      applyStimulus(1, 1, 1, 5'd1, 6'd10, 0, 5'd0, 6'd0, 1);
      expectOut("redir_cycle_count", 2, 28);
      checkOutput();
      cycle();
      idle();
      expectOut("redir_alloc0", 0, 33);
      expectOut("redir_count",  2, 32);
      expectOut("redir_ready",  3, 1);
      checkOutput();

      // Asynchronous reset mid-drain.
      pulseReset();
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1, 1, 0, 5'd0, 6'd0, 0, 5'd0, 6'd0, 0);
         cycle();
      end
      expectOut("middrain_count", 2, 10);
      checkOutput();
      alloc1_req = 1'b0;
      #1;
      reset_n = 1'b0;
      expectResetOutputs("async_rst");
      checkOutput();
      @(posedge clock);
      #1;
      expectResetOutputs("async_rst_held");
      checkOutput();
      @(negedge clock);
      idle();
      reset_n = 1'b1;
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
